// File: rtl/rc2014_io_read_port.sv
// Z80 IN responder: serves a 2^DEPTH_LOG2-byte receive FIFO on DATA_PORT and a status byte on STATUS_PORT.
// Latency: D_OE rises 4 CLK edges after /RD,/IORQ fall; falls 2-3 edges after either rises.
// Backpressure: PUSH_READY low while full; pushes into a full FIFO are dropped and set sticky overflow.
module rc2014_io_read_port #(
  parameter logic [7:0] DATA_PORT   = 8'hC0,
  parameter logic [7:0] STATUS_PORT = 8'hC1,
  parameter int         DEPTH_LOG2  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] A,
  input  logic       RD,
  input  logic       IORQ,
  input  logic       M1,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       DATA_DIR,
  input  logic       PUSH_VALID,
  input  logic [7:0] PUSH_DATA,
  output logic       PUSH_READY,
  output logic       RX_AVAIL
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRIVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0] rd_sync, iorq_sync, m1_sync;
  logic [7:0] a_sync1, a_sync2;

  logic       addr_data, addr_stat, bus_match;
  logic       capture_go, release_go;
  logic       port_is_data;   // which port matched, latched on entry to CAPTURE
  logic       sel_data;       // port of the cycle in progress, latched in CAPTURE
  logic       pop_pend;       // data read that found the FIFO non-empty

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  full, empty;
  logic                  push_ok, pop, ovf_set, ovf_clr;
  logic [7:0]            status_byte;

  // Two-flop synchronizers; bus strobes idle high so reset to the inactive level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_sync   <= 2'b11;
      iorq_sync <= 2'b11;
      m1_sync   <= 2'b11;
      a_sync1   <= 8'h00;
      a_sync2   <= 8'h00;
    end else begin
      rd_sync   <= {rd_sync[0], RD};
      iorq_sync <= {iorq_sync[0], IORQ};
      m1_sync   <= {m1_sync[0], M1};
      a_sync1   <= A;
      a_sync2   <= a_sync1;
    end
  end

  assign addr_data = (a_sync2 == DATA_PORT);
  assign addr_stat = (a_sync2 == STATUS_PORT);
  // /M1 low with /IORQ low is an interrupt acknowledge and must never be answered.
  assign bus_match = !iorq_sync[1] && !rd_sync[1] && m1_sync[1] && (addr_data || addr_stat);

  // Bus-cycle state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus single-cycle capture/release strobes.
  always_comb begin
    state_nxt  = state;
    capture_go = 1'b0;
    release_go = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus_match) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture_go = 1'b1;
        state_nxt  = S_DRIVE;
      end
      S_DRIVE: begin
        if (rd_sync[1] || iorq_sync[1]) begin
          release_go = 1'b1;
          state_nxt  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign status_byte = {5'b00000, overflow, full, !empty};

  // Latch the response byte and remember what the end of the cycle must do.
  always_ff @(posedge CLK) begin
    if (RST) begin
      port_is_data <= 1'b0;
      sel_data     <= 1'b0;
      pop_pend     <= 1'b0;
      D_OUT        <= 8'h00;
    end else begin
      if (state == S_IDLE && bus_match) port_is_data <= addr_data;
      if (capture_go) begin
        sel_data <= port_is_data;
        pop_pend <= port_is_data && !empty;
        if (port_is_data) D_OUT <= empty ? 8'hFF : mem[rd_ptr];
        else              D_OUT <= status_byte;
      end
    end
  end

  // Pad enable is a flop so the level-shifter direction never glitches.
  always_ff @(posedge CLK) begin
    if (RST) D_OE <= 1'b0;
    else     D_OE <= (state_nxt == S_DRIVE);
  end

  assign DATA_DIR = D_OE;

  // Full is judged on the registered count, so a pop in the same cycle frees no room.
  assign push_ok = PUSH_VALID && !full;
  assign ovf_set = PUSH_VALID && full;
  assign pop     = release_go && pop_pend;
  assign ovf_clr = release_go && !sel_data;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= PUSH_DATA;
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign PUSH_READY = !full;
  assign RX_AVAIL   = !empty;

endmodule

// File: tb/tb_rc2014_io_read_port.sv
// Randomized scoreboard bench for rc2014_io_read_port.
// Bus cycles are driven on the falling clock edge; a monitor checks every byte the DUT drives.
// A queue-based model of the FIFO and overflow flag supplies every expected value.
module tb_rc2014_io_read_port;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] A;
  logic       RD, IORQ, M1;
  logic [7:0] D_OUT;
  logic       D_OE, DATA_DIR;
  logic       PUSH_VALID;
  logic [7:0] PUSH_DATA;
  logic       PUSH_READY, RX_AVAIL;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];      // model FIFO contents
  bit         movf;       // model sticky overflow
  logic [7:0] exp_q[$];   // bytes the bus is expected to see, in order

  logic       mon_prev_oe;
  logic [7:0] mon_held;
  logic [7:0] mon_exp;

  rc2014_io_read_port #(
    .DATA_PORT  (8'hC0),
    .STATUS_PORT(8'hC1),
    .DEPTH_LOG2 (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .RD        (RD),
    .IORQ      (IORQ),
    .M1        (M1),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .DATA_DIR  (DATA_DIR),
    .PUSH_VALID(PUSH_VALID),
    .PUSH_DATA (PUSH_DATA),
    .PUSH_READY(PUSH_READY),
    .RX_AVAIL  (RX_AVAIL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    chk("rx_avail", RX_AVAIL, int'(mq.size() != 0));
    chk("push_ready", PUSH_READY, int'(mq.size() < 16));
  endtask

  // One-cycle push offer; the model accepts it only if not full.
  task automatic push_byte(input logic [7:0] d);
    PUSH_VALID = 1'b1;
    PUSH_DATA  = d;
    if (mq.size() < 16) mq.push_back(d);
    else                movf = 1'b1;
    @(negedge CLK);
    PUSH_VALID = 1'b0;
    check_flags();
  endtask

  // A complete Z80 IN cycle. ack=1 makes it an interrupt acknowledge.
  // pp=1 offers pdata on exactly the edge at which the read pops.
  task automatic in_cycle(input logic [7:0] addr, input bit ack, input int hold,
                          input bit pp, input logic [7:0] pdata);
    bit         is_match;
    int         pre_size;
    int         lat;
    logic [7:0] eb;
    is_match = !ack && (addr == 8'hC0 || addr == 8'hC1);
    pre_size = mq.size();
    if (is_match) begin
      if (addr == 8'hC0) begin
        if (pre_size > 0) eb = mq.pop_front();
        else              eb = 8'hFF;
      end else begin
        eb   = {5'b00000, movf, pre_size == 16, pre_size != 0};
        movf = 1'b0;
      end
      if (pp) begin
        if (pre_size == 16) movf = 1'b1;
        else                mq.push_back(pdata);
      end
      exp_q.push_back(eb);
    end
    A    = addr;
    M1   = ack ? 1'b0 : 1'b1;
    IORQ = 1'b0;
    RD   = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (D_OE && lat == 0) lat = c;
      if (is_match && lat != 0) break;
    end
    if (is_match) begin
      chk("oe_latency", lat, 4);
      repeat (hold) @(negedge CLK);
      chk("rx_avail_before_pop", RX_AVAIL, int'(pre_size != 0));
    end else begin
      chk("no_drive", lat, 0);
    end
    RD   = 1'b1;
    IORQ = 1'b1;
    M1   = 1'b1;
    @(negedge CLK);
    if (is_match) chk("oe_hold", D_OE, 1);
    @(negedge CLK);
    if (pp) begin
      PUSH_VALID = 1'b1;
      PUSH_DATA  = pdata;
    end
    @(negedge CLK);
    PUSH_VALID = 1'b0;
    if (is_match) chk("oe_release", D_OE, 0);
    @(negedge CLK);
    @(negedge CLK);
    check_flags();
  endtask

  // Monitor: every rising D_OE must present the next scoreboard byte, held while driven.
  initial begin
    mon_prev_oe = 1'b0;
    mon_held    = 8'h00;
    forever begin
      @(negedge CLK);
      chk("data_dir", DATA_DIR, D_OE);
      if (D_OE && !mon_prev_oe) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_drive", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("bus_byte", D_OUT, mon_exp);
        end
        mon_held = D_OUT;
      end else if (D_OE && mon_prev_oe) begin
        chk("dout_stable", D_OUT, mon_held);
      end
      mon_prev_oe = D_OE;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [7:0] addr;
    int         r;
    int         lat;
    RST = 1'b1; A = 8'h00; RD = 1'b1; IORQ = 1'b1; M1 = 1'b1;
    PUSH_VALID = 1'b0; PUSH_DATA = 8'h00;
    movf = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_d_oe", D_OE, 0);
    chk("rst_data_dir", DATA_DIR, 0);
    chk("rst_d_out", D_OUT, 8'h00);
    chk("rst_push_ready", PUSH_READY, 1);
    chk("rst_rx_avail", RX_AVAIL, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Empty data read returns FF.
    in_cycle(8'hC0, 1'b0, 2, 1'b0, 8'h00);

    // Two bytes come back in order, popping only at end of cycle.
    push_byte(8'h41);
    push_byte(8'h42);
    in_cycle(8'hC0, 1'b0, 3, 1'b0, 8'h00);
    in_cycle(8'hC0, 1'b0, 1, 1'b0, 8'h00);

    // Fill past full, then status reads with and without overflow.
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    in_cycle(8'hC1, 1'b0, 1, 1'b0, 8'h00);
    in_cycle(8'hC1, 1'b0, 1, 1'b0, 8'h00);

    // Drain to 5 entries, then push on the pop edge: count stays 5.
    for (int i = 0; i < 11; i++) in_cycle(8'hC0, 1'b0, 0, 1'b0, 8'h00);
    in_cycle(8'hC0, 1'b0, 1, 1'b1, 8'hA5);
    // Refill to 16; push on the pop edge of a full FIFO is refused.
    for (int i = 0; i < 11; i++) push_byte(8'h80 + 8'(i));
    in_cycle(8'hC0, 1'b0, 1, 1'b1, 8'h5A);
    in_cycle(8'hC1, 1'b0, 1, 1'b0, 8'h00);
    while (mq.size() > 0) in_cycle(8'hC0, 1'b0, 0, 1'b0, 8'h00);
    in_cycle(8'hC0, 1'b0, 0, 1'b0, 8'h00);

    // Interrupt acknowledge to the data port is ignored.
    push_byte(8'h77);
    in_cycle(8'hC0, 1'b1, 0, 1'b0, 8'h00);
    in_cycle(8'hC0, 1'b0, 1, 1'b0, 8'h00);

    // Reset while driving a data read: bus released, FIFO emptied, no pop later.
    for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i));
    exp_q.push_back(mq[0]);
    A = 8'hC0; M1 = 1'b1; IORQ = 1'b0; RD = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (D_OE) begin
        lat = c;
        break;
      end
    end
    chk("oe_latency_rst", lat, 4);
    RST = 1'b1;
    @(negedge CLK);
    chk("oe_after_rst", D_OE, 0);
    RD = 1'b1; IORQ = 1'b1;
    mq.delete();
    movf = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_flags();
    repeat (4) @(negedge CLK);
    check_flags();
    in_cycle(8'hC1, 1'b0, 1, 1'b0, 8'h00);
    in_cycle(8'hC0, 1'b0, 1, 1'b0, 8'h00);

    // Randomized mix of pushes, reads, misses and acknowledges.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        push_byte(8'($urandom));
      end else if (r <= 6) begin
        in_cycle(8'hC0, 1'b0, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 8'($urandom));
      end else if (r == 7) begin
        in_cycle(8'hC1, 1'b0, $urandom_range(0, 3), 1'b0, 8'h00);
      end else if (r == 8) begin
        addr = 8'($urandom);
        if (addr == 8'hC0 || addr == 8'hC1) addr = addr ^ 8'h10;
        in_cycle(addr, 1'b0, 0, 1'b0, 8'h00);
      end else begin
        in_cycle($urandom_range(0, 1) ? 8'hC0 : 8'hC1, 1'b1, 0, 1'b0, 8'h00);
      end
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc2014_io_read_port.md
# rc2014_io_read_port

Z80 I/O read responder for the RC2014 bus: answers `IN` instructions on two configurable port addresses. It drives bytes from a 16-entry receive FIFO onto the data bus, and exposes a status byte. It is the bus-read counterpart of the existing port-write decoder. It sits between the RC2014 edge-connector pins (via the level-shifter direction controls) and FPGA-internal producers such as a UART receiver or button-event logic.

## Interface
- `DATA_PORT`, 8'hC0: I/O address whose read pops the FIFO.
- `STATUS_PORT`, 8'hC1: I/O address whose read returns the status byte.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries.

- `CLK`: input, 1 bit. FPGA system clock; all logic on the rising edge.
- `RST`: input, 1 bit. Reset, synchronous and active-high.
- `A`: input, 8 bits. Z80 address bus low byte; asynchronous to `CLK`.
- `RD`: input, 1 bit. Z80 /RD, active-low, asynchronous.
- `IORQ`: input, 1 bit. Z80 /IORQ, active-low, asynchronous.
- `M1`: input, 1 bit. Z80 /M1, active-low, asynchronous.
- `D_OUT`: output, 8 bits. Byte presented to the data bus pads.
- `D_OE`: output, 1 bit. Data pad output enable, 1 = drive bus.
- `DATA_DIR`: output, 1 bit. Data level-shifter direction, 1 = FPGA→bus; always equal to `D_OE`.
- `PUSH_VALID`: input, 1 bit. Internal producer offers `PUSH_DATA`.
- `PUSH_DATA`: input, 8 bits. Byte to enqueue.
- `PUSH_READY`: output, 1 bit. High when the FIFO is not full.
- `RX_AVAIL`: output, 1 bit. FIFO non-empty; usable as an interrupt request source.

## Operation
- `RD`, `IORQ` and `M1` each pass through a 2-FF synchronizer. `A` is sampled from a 2-FF synchronized copy in the same cycle the control signals are evaluated.
- A match is: synced `IORQ`=0, `RD`=0, `M1`=1, and synced `A` equal to `DATA_PORT` or `STATUS_PORT`. `IORQ`=0 with `M1`=0 (interrupt acknowledge) never matches.
- FSM states:
  - IDLE → CAPTURE on a match.
  - CAPTURE → DRIVE unconditionally.
  - DRIVE → RELEASE when synced `RD`=1 or `IORQ`=1.
  - RELEASE → IDLE unconditionally.
- CAPTURE latches the response byte into `D_OUT` and records which port matched.
  - Data port, FIFO non-empty: head byte.
  - Data port, FIFO empty: 8'hFF.
  - Status port: {5'b0, overflow, full, !empty}.
- `D_OUT` is held constant from CAPTURE until the next CAPTURE.
- On entry to RELEASE (end of bus cycle):
  - Data port with FIFO non-empty at CAPTURE: pop one entry.
  - Status port: clear the sticky overflow flag.
  - Data port read when empty: no pop.
- Push: accepted when `PUSH_VALID`=1 and not full.
  - Push while full: byte dropped, overflow set.
  - Overflow set and status-read clear in the same cycle: set wins.
- Simultaneous push and pop: both occur and the count is unchanged.
  - When full, the pop frees no room that cycle; `PUSH_READY` still reflects the pre-pop full state, so the push is refused and sets overflow.
- Count width is DEPTH_LOG2+1 bits; read and write pointers wrap modulo 2^DEPTH_LOG2.
- `RST` mid-cycle: next edge returns to IDLE, `D_OE`=0, FIFO empty, overflow clear; the bus cycle is abandoned with no pop.

## Timing
- Reset values: `D_OE`=0, `DATA_DIR`=0, `D_OUT`=8'h00, `PUSH_READY`=1, `RX_AVAIL`=0, FIFO empty, overflow=0, state IDLE.
- Bus-to-match latency is 2 `CLK` cycles (synchronizer). CAPTURE is 1 cycle later; `D_OE`/`DATA_DIR` rise on the edge entering DRIVE, i.e. 4 cycles after /RD and /IORQ fall.
- `D_OE` falls on the edge entering RELEASE, 2–3 cycles after /RD or /IORQ rises.
- With `CLK` ≥ 8× the Z80 clock, data is valid before the T3 sampling edge. The system clock is required to meet that ratio.
- `PUSH_READY` and `RX_AVAIL` are registered-count derived, valid the cycle after any push or pop.
- A new match cannot start before IDLE is re-entered; back-to-back `IN`s are separated by ≥1 bus T-state, which is sufficient.

## Test plan
- Reset, then `IN` from 8'hC0 with the FIFO empty → `D_OUT`=8'hFF while `D_OE`=1, count stays 0, `RX_AVAIL`=0.
- Push 8'h41, 8'h42, then two `IN`s from 8'hC0 → the bus sees 8'h41 then 8'h42, count returns to 0, and no pop occurs until /RD rises.
- Push 17 bytes (0x00–0x10) → `PUSH_READY`=0 after the 16th. `IN` from 8'hC1 returns 8'h07; a second `IN` from 8'hC1 returns 8'h03 (overflow cleared).
- Interrupt acknowledge (/M1=0, /IORQ=0, `A`=8'hC0) with FIFO non-empty → `D_OE` stays 0, no pop.
- Push on the same cycle as a pop at count 5 → count stays 5 and byte order is preserved. The same at count 16 → pushed byte dropped, overflow=1.
- Assert `RST` while in DRIVE during a data-port read → `D_OE`=0 on the next edge, FIFO empty, no spurious pop after reset.
